seq_datapath: RTL and testbench

//  Parametrised successor to the lab datapath: register file, B-operand shifter, ALU, A/B/C regs, status.

---
 rtl/seq_datapath_pkg.sv | 42 ++++
 rtl/seq_datapath_if.sv | 51 +++++
 rtl/seq_datapath_regfile.sv | 41 ++++
 rtl/seq_datapath.sv | 192 +++++++++++++++++++
 tb/tb_seq_datapath.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_datapath_pkg.sv
// seq_datapath_pkg: shared types and constants for the sequenced datapath.
//   op_kind_e : op classes decoded by the micro-sequencer
//   alu_op_e  : ALU functions
//   shift_e   : B-operand shifter modes
//   state_e   : micro-sequencer states
//   Z_BIT/N_BIT/V_BIT : bit positions inside the 3-bit status word
package seq_datapath_pkg;

    typedef enum logic [1:0] {
        K_MOV_IMM = 2'b00,
        K_MOV_REG = 2'b01,
        K_ALU     = 2'b10,
        K_CMP     = 2'b11
    } op_kind_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_MVN = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDB  = 3'd1,
        LDA  = 3'd2,
        EXE  = 3'd3,
        WB   = 3'd4
    } state_e;

    localparam int unsigned Z_BIT = 0;
    localparam int unsigned N_BIT = 1;
    localparam int unsigned V_BIT = 2;

endpackage

// File: rtl/seq_datapath_if.sv
// seq_datapath_if: op request / result / debug bundle of seq_datapath.
//   master : op source (instruction decoder) - drives op_* and dbg_addr
//   slave  : the datapath - drives op_ready, done, result, status, dbg_data
// Optional macro DATAPATH_SHAMT_EN adds the op_shamt field.
interface seq_datapath_if #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned IMMW = 8
);
    localparam int unsigned RW = $clog2(NREG);
`ifdef DATAPATH_SHAMT_EN
    localparam int unsigned SW = $clog2(DW);
`endif

    logic            op_valid;
    logic            op_ready;
    logic [1:0]      op_kind;
    logic [1:0]      op_alu;
    logic [1:0]      op_shift;
`ifdef DATAPATH_SHAMT_EN
    logic [SW-1:0]   op_shamt;
`endif
    logic [RW-1:0]   op_rd;
    logic [RW-1:0]   op_rn;
    logic [RW-1:0]   op_rm;
    logic [IMMW-1:0] op_imm;
    logic            done;
    logic [DW-1:0]   result;
    logic [2:0]      status;
    logic [RW-1:0]   dbg_addr;
    logic [DW-1:0]   dbg_data;

    modport master (
        output op_valid, op_kind, op_alu, op_shift,
`ifdef DATAPATH_SHAMT_EN
        output op_shamt,
`endif
        output op_rd, op_rn, op_rm, op_imm, dbg_addr,
        input  op_ready, done, result, status, dbg_data
    );

    modport slave (
        input  op_valid, op_kind, op_alu, op_shift,
`ifdef DATAPATH_SHAMT_EN
        input  op_shamt,
`endif
        input  op_rd, op_rn, op_rm, op_imm, dbg_addr,
        output op_ready, done, result, status, dbg_data
    );

endinterface

// File: rtl/seq_datapath_regfile.sv
// dp_regfile: NREG x DW general-purpose register file.
//   clk, rst_n        : clock, asynchronous active-low reset (clears all registers)
//   we, waddr, wdata  : single synchronous write port
//   raddr_a / rdata_a : combinational read (A operand, Rn)
//   raddr_b / rdata_b : combinational read (B operand, Rm)
//   dbg_addr/dbg_data : combinational debug read
module dp_regfile #(
    parameter  int unsigned DW   = 16,
    parameter  int unsigned NREG = 8,
    localparam int unsigned RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [RW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [RW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/seq_datapath.sv
// seq_datapath: register file + B shifter + ALU + A/B/C/status registers,
// driven by a micro-sequencer so one accepted op runs load/exec/writeback.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : seq_datapath_if.slave - op request (valid/ready + fields),
//            done pulse, result (C), status {V,N,Z}, debug register read
// Optional macro DATAPATH_SHAMT_EN: shift amount taken from op_shamt
// (0 = no shift); otherwise LSL/LSR/ASR shift by exactly one.
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned IMMW = 8
) (
    input logic            clk,
    input logic            rst_n,
    seq_datapath_if.slave  bus
);

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned SW = $clog2(DW);

    state_e          state_q, state_d;
    logic            accept;

    // op fields captured on accept
    op_kind_e        kind_q;
    alu_op_e         alu_q;
    shift_e          shift_q;
    logic [RW-1:0]   rd_q, rn_q, rm_q;
    logic [IMMW-1:0] imm_q;
`ifdef DATAPATH_SHAMT_EN
    logic [SW-1:0]   shamt_q;
`endif

    logic [DW-1:0]   a_q, b_q, c_q;
    logic [2:0]      status_q;

    logic [DW-1:0]   rn_data, rm_data, dbg_data;
    logic            wr_en;
    logic [SW-1:0]   shamt;
    logic [DW-1:0]   sh_b, a_op, alu_res, imm_ext;
    alu_op_e         alu_sel;
    logic            alu_v;
    logic [2:0]      alu_flags;

    assign accept = (state_q == IDLE) && bus.op_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q  <= K_MOV_IMM;
            alu_q   <= ALU_ADD;
            shift_q <= SH_NONE;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            imm_q   <= '0;
`ifdef DATAPATH_SHAMT_EN
            shamt_q <= '0;
`endif
        end else if (accept) begin
            kind_q  <= op_kind_e'(bus.op_kind);
            alu_q   <= alu_op_e'(bus.op_alu);
            shift_q <= shift_e'(bus.op_shift);
            rd_q    <= bus.op_rd;
            rn_q    <= bus.op_rn;
            rm_q    <= bus.op_rm;
            imm_q   <= bus.op_imm;
`ifdef DATAPATH_SHAMT_EN
            shamt_q <= bus.op_shamt;
`endif
        end
    end

    dp_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en),
        .waddr    (rd_q),
        .wdata    (c_q),
        .raddr_a  (rn_q),
        .rdata_a  (rn_data),
        .raddr_b  (rm_q),
        .rdata_b  (rm_data),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (dbg_data)
    );

    // micro-sequencer: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // micro-sequencer: next state. The kind is read from the bus in IDLE
    // (not yet captured) and from kind_q afterwards.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    if (op_kind_e'(bus.op_kind) == K_MOV_IMM) state_d = EXE;
                    else                                     state_d = LDB;
                end
            end
            LDB:     state_d = (kind_q == K_MOV_REG) ? EXE : LDA;
            LDA:     state_d = EXE;
            EXE:     state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef DATAPATH_SHAMT_EN
    assign shamt = shamt_q;
`else
    assign shamt = SW'(1);
`endif

    // B-operand shifter
    always_comb begin
        sh_b = b_q;
        case (shift_q)
            SH_LSL:  sh_b = b_q << shamt;
            SH_LSR:  sh_b = b_q >> shamt;
            SH_ASR:  sh_b = $signed(b_q) >>> shamt;
            default: sh_b = b_q;
        endcase
    end

    // ALU. MOV_REG is 0 + sh(Rm); CMP always subtracts, whatever op_alu says.
    always_comb begin
        a_op = (kind_q == K_MOV_REG) ? '0 : a_q;
        case (kind_q)
            K_ALU:   alu_sel = alu_q;
            K_CMP:   alu_sel = ALU_SUB;
            default: alu_sel = ALU_ADD;
        endcase
        alu_res = '0;
        alu_v   = 1'b0;
        case (alu_sel)
            ALU_ADD: begin
                alu_res = a_op + sh_b;
                alu_v   = (a_op[DW-1] == sh_b[DW-1]) && (alu_res[DW-1] != a_op[DW-1]);
            end
            ALU_SUB: begin
                alu_res = a_op - sh_b;
                alu_v   = (a_op[DW-1] != sh_b[DW-1]) && (alu_res[DW-1] != a_op[DW-1]);
            end
            ALU_AND: alu_res = a_op & sh_b;
            default: alu_res = ~sh_b;
        endcase
        alu_flags        = '0;
        alu_flags[Z_BIT] = (alu_res == '0);
        alu_flags[N_BIT] = alu_res[DW-1];
        alu_flags[V_BIT] = alu_v;
    end

    assign imm_ext = {{(DW-IMMW){imm_q[IMMW-1]}}, imm_q};

    // A/B/C/status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            case (state_q)
                LDB: b_q <= rm_data;
                LDA: a_q <= rn_data;
                EXE: begin
                    c_q <= (kind_q == K_MOV_IMM) ? imm_ext : alu_res;
                    if (kind_q == K_ALU || kind_q == K_CMP) status_q <= alu_flags;
                end
                default: ;
            endcase
        end
    end

    assign wr_en        = (state_q == WB) && (kind_q != K_CMP);
    assign bus.op_ready = (state_q == IDLE);
    assign bus.done     = (state_q == WB);
    assign bus.result   = c_q;
    assign bus.status   = status_q;
    assign bus.dbg_data = dbg_data;

endmodule

// File: tb/tb_seq_datapath.sv
module tb_seq_datapath;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    longint   m_reg [8];
    logic [2:0] m_st;
    logic [15:0] got_res;
    logic [2:0]  got_st;
    logic [15:0] rv;

    seq_datapath_if #(.DW(16), .NREG(8), .IMMW(8)) bus ();

    seq_datapath #(.DW(16), .NREG(8), .IMMW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic longint s16(input longint x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    function automatic longint to16(input longint x);
        return ((x % 65536) + 65536) % 65536;
    endfunction

    task automatic read_reg(input int idx, output logic [15:0] v);
        bus.dbg_addr = 3'(idx);
        #1;
        v = bus.dbg_data;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_st = 3'b000;
    endtask

    // Starts at a falling edge with the datapath idle; returns at the falling
    // edge after the op has written back, datapath idle again.
    task automatic do_op(input int k, input int al, input int s, input int sa,
                         input int rd, input int rn, input int rm, input int imm,
                         input bit hold);
        longint av, bv, r, t, p, sb;
        int     amt, elat, lat;
        bit     v, upd;
        logic [2:0] est;
`ifdef DATAPATH_SHAMT_EN
        amt = sa;
`else
        amt = 1;
`endif
        // reference: operand rules written as plain arithmetic on integers
        p  = longint'(1) << amt;
        bv = m_reg[rm];
        case (s)
            1: bv = to16(bv * p);
            2: bv = bv / p;
            3: begin
                sb = s16(bv);
                sb = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
                bv = to16(sb);
            end
            default: ;
        endcase
        av = m_reg[rn];
        v = 0; upd = 0; r = 0;
        case (k)
            0: begin r = (imm >= 128) ? imm + 65280 : imm; elat = 2; end
            1: begin r = bv; elat = 3; end
            default: begin
                elat = 4; upd = 1;
                case ((k == 3) ? 1 : al)
                    0: begin t = s16(av) + s16(bv); r = to16(av + bv); v = (t > 32767) || (t < -32768); end
                    1: begin t = s16(av) - s16(bv); r = to16(av - bv); v = (t > 32767) || (t < -32768); end
                    2: r = av & bv;
                    default: r = 65535 - bv;
                endcase
            end
        endcase
        est = upd ? {v, (r >= 32768), (r == 0)} : m_st;

        chk("ready_idle", bus.op_ready, 1);
        bus.op_kind  = 2'(k);
        bus.op_alu   = 2'(al);
        bus.op_shift = 2'(s);
`ifdef DATAPATH_SHAMT_EN
        bus.op_shamt = 4'(sa);
`endif
        bus.op_rd    = 3'(rd);
        bus.op_rn    = 3'(rn);
        bus.op_rm    = 3'(rm);
        bus.op_imm   = 8'(imm);
        bus.op_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        while (1) begin
            @(negedge clk);
            if (bus.done) begin
                bus.op_valid = 1'b0;
                break;
            end
            if (hold) begin
                bus.op_kind  = 2'($urandom);
                bus.op_alu   = 2'($urandom);
                bus.op_shift = 2'($urandom);
                bus.op_rd    = 3'($urandom);
                bus.op_rn    = 3'($urandom);
                bus.op_rm    = 3'($urandom);
                bus.op_imm   = 8'($urandom);
            end else begin
                bus.op_valid = 1'b0;
            end
            chk("ready_busy", bus.op_ready, 0);
            if (lat > 8) begin
                chk("done_timeout", 0, 1);
                break;
            end
            lat++;
        end
        got_res = bus.result;
        got_st  = bus.status;
        chk("ready_wb", bus.op_ready, 0);
        chk("latency", lat, elat);
        chk("result", got_res, 32'(r));
        chk("status", got_st, est);
        if (k != 3) m_reg[rd] = r;
        m_st = est;
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        read_reg(rd, rv);
        chk("reg_rd", rv, 32'(m_reg[rd]));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_model();
        bus.op_valid = 1'b0;
        bus.op_kind  = '0;
        bus.op_alu   = '0;
        bus.op_shift = '0;
`ifdef DATAPATH_SHAMT_EN
        bus.op_shamt = '0;
`endif
        bus.op_rd    = '0;
        bus.op_rn    = '0;
        bus.op_rm    = '0;
        bus.op_imm   = '0;
        bus.dbg_addr = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", bus.op_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_status", bus.status, 0);
        for (int i = 0; i < 8; i++) begin
            read_reg(i, rv);
            chk("rst_reg", rv, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: MOV_IMM R0,#7; MOV_IMM R1,#2; ADD R2,R1,R0 LSL
        do_op(0, 0, 0, 0, 0, 0, 0, 7, 0);
        do_op(0, 0, 0, 0, 1, 0, 0, 2, 0);
        do_op(2, 0, 1, 1, 2, 1, 0, 0, 0);
        read_reg(2, rv);
        chk("t1_r2", rv, 16);
        chk("t1_status", got_st, 3'b000);

        // 2: MOV_IMM R5,#0x55; SUB R6,R5,R2 LSR
        do_op(0, 0, 0, 0, 5, 0, 0, 8'h55, 0);
        do_op(2, 1, 2, 1, 6, 5, 2, 0, 0);
        chk("t2_result", got_res, 77);
        read_reg(6, rv);
        chk("t2_r6", rv, 77);

        // 3: MOV_IMM R3,#0x80 then CMP R3,R3
        do_op(0, 0, 0, 0, 3, 0, 0, 8'h80, 0);
        read_reg(3, rv);
        chk("t3_sext", rv, 16'hFF80);
        do_op(3, 2, 0, 0, 3, 3, 3, 0, 0);
        chk("t3_cmp_z", got_st, 3'b001);
        read_reg(3, rv);
        chk("t3_r3_kept", rv, 16'hFF80);

        // 4: MVN R7,R3 LSR; SUB R1,R7,R5
        do_op(2, 3, 2, 1, 7, 0, 3, 0, 0);
        chk("t4_mvn", got_res, 16'h803F);
        chk("t4_n", got_st, 3'b010);
        do_op(2, 1, 0, 0, 1, 7, 5, 0, 0);
        chk("t4_r1", got_res, 16'h7FEA);
        chk("t4_v", got_st, 3'b100);

        // 5: fields toggled while busy; MOV_REG and rd==rn==rm
        do_op(2, 0, 0, 0, 4, 2, 6, 0, 1);
        do_op(1, 0, 3, 1, 0, 0, 3, 0, 1);
        do_op(2, 0, 1, 1, 6, 6, 6, 0, 0);

        // reset during EXE of an ALU op
        bus.op_kind = 2'd2; bus.op_alu = 2'd0; bus.op_shift = 2'd0;
        bus.op_rd = 3'd4; bus.op_rn = 3'd2; bus.op_rm = 3'd6;
        bus.op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", bus.op_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.op_ready, 1);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_result", bus.result, 0);
        for (int i = 0; i < 8; i++) begin
            read_reg(i, rv);
            chk("mid_rst_reg", rv, 0);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", bus.done, 0);
        end

`ifdef DATAPATH_SHAMT_EN
        // 6: variable shift amount
        do_op(0, 0, 0, 0, 0, 0, 0, 7, 0);
        do_op(0, 0, 0, 0, 1, 0, 0, 2, 0);
        do_op(2, 0, 1, 3, 2, 1, 0, 0, 0);
        chk("t6_lsl3", got_res, 58);
        do_op(0, 0, 0, 0, 3, 0, 0, 8'h80, 0);
        do_op(1, 0, 3, 15, 4, 0, 3, 0, 0);
        chk("t6_asr15", got_res, 16'hFFFF);
`endif

        // randomized ops against the reference
        for (int n = 0; n < 150; n++) begin
            do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
